writeback_arbiter: RTL and testbench

- Writeback stage directly upstream of the 32x32 register file.
- Merges two result sources into the single register-file write port (reg_wren / write_address / write_data):
  - the single-cycle ALU path, which has priority and no backpressure;
  - the long-latency memory/muldiv path, which uses a valid/ready handshake and is buffered in a small FIFO.
- Drops x0 writes and reports pending destinations so the issue logic can stall on RAW hazards.

---
 rtl/writeback_arbiter_if.sv | 50 +++++
 rtl/writeback_arbiter.sv | 121 ++++++++++++
 tb/tb_writeback_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_arbiter_if.sv
// Writeback arbiter bus: ALU result, memory-path handshake, hazard lookup and register-file write port.
// The optional bypass outputs exist only when WRITEBACK_BYPASS_EN is defined.
interface writeback_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  logic                     alu_valid;
  logic [4:0]               alu_rd;
  logic [XLEN-1:0]          alu_data;
  logic                     mem_valid;
  logic                     mem_ready;
  logic [4:0]               mem_rd;
  logic [XLEN-1:0]          mem_data;
  logic [4:0]               read_address1;
  logic [4:0]               read_address2;
  logic                     pending_hit1;
  logic                     pending_hit2;
  logic                     reg_wren;
  logic [4:0]               write_address;
  logic [XLEN-1:0]          write_data;
  logic [$clog2(DEPTH):0]   fifo_count;
`ifdef WRITEBACK_BYPASS_EN
  logic                     bypass_hit1;
  logic                     bypass_hit2;
  logic [XLEN-1:0]          bypass_data1;
  logic [XLEN-1:0]          bypass_data2;
`endif

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  read_address1, read_address2,
    output mem_ready, pending_hit1, pending_hit2,
    output reg_wren, write_address, write_data, fifo_count
`ifdef WRITEBACK_BYPASS_EN
    , output bypass_hit1, bypass_hit2, bypass_data1, bypass_data2
`endif
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output read_address1, read_address2,
    input  mem_ready, pending_hit1, pending_hit2,
    input  reg_wren, write_address, write_data, fifo_count
`ifdef WRITEBACK_BYPASS_EN
    , input bypass_hit1, bypass_hit2, bypass_data1, bypass_data2
`endif
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges the ALU result (priority) and the buffered memory/muldiv path into one register-file write port.
// Optional feature macro: WRITEBACK_BYPASS_EN adds same-cycle bypass outputs for the read stage.
module writeback_arbiter #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input logic                clk,
  input logic                reset,
  writeback_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]      r_fifoRd   [DEPTH];
  logic [XLEN-1:0] r_fifoData [DEPTH];
  logic [DEPTH-1:0] r_entryValid;
  logic [AW-1:0]   r_rdPtr;
  logic [AW-1:0]   r_wrPtr;
  logic [CW-1:0]   r_count;
  logic            r_wren;
  logic [4:0]      r_writeAddress;
  logic [XLEN-1:0] r_writeData;

  logic w_aluReq;
  logic w_ready;
  logic w_push;
  logic w_pop;
  logic w_hit1;
  logic w_hit2;

  // Ready is held low during reset even though the count is already zero.
  assign w_ready  = !reset && (r_count != CW'(DEPTH));
  assign w_aluReq = bus.alu_valid && (bus.alu_rd != 5'd0);
  assign w_push   = bus.mem_valid && w_ready && (bus.mem_rd != 5'd0);
  assign w_pop    = !w_aluReq && (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifoRd[r_wrPtr]   <= bus.mem_rd;
      r_fifoData[r_wrPtr] <= bus.mem_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdPtr      <= '0;
      r_wrPtr      <= '0;
      r_count      <= '0;
      r_entryValid <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      // A slot popped and refilled in the same cycle must stay valid, hence the push wins.
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push && (r_wrPtr == AW'(i))) begin
          r_entryValid[i] <= 1'b1;
        end else if (w_pop && (r_rdPtr == AW'(i))) begin
          r_entryValid[i] <= 1'b0;
        end
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wren         <= 1'b0;
      r_writeAddress <= '0;
      r_writeData    <= '0;
    end else if (w_aluReq) begin
      r_wren         <= 1'b1;
      r_writeAddress <= bus.alu_rd;
      r_writeData    <= bus.alu_data;
    end else if (w_pop) begin
      r_wren         <= 1'b1;
      r_writeAddress <= r_fifoRd[r_rdPtr];
      r_writeData    <= r_fifoData[r_rdPtr];
    end else begin
      r_wren <= 1'b0;
    end
  end

  // Only queued entries count as pending; the output stage is covered by the bypass instead.
  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_entryValid[i] && (r_fifoRd[i] == bus.read_address1)) begin
        w_hit1 = 1'b1;
      end
      if (r_entryValid[i] && (r_fifoRd[i] == bus.read_address2)) begin
        w_hit2 = 1'b1;
      end
    end
    if (bus.read_address1 == 5'd0) begin
      w_hit1 = 1'b0;
    end
    if (bus.read_address2 == 5'd0) begin
      w_hit2 = 1'b0;
    end
  end

  assign bus.mem_ready     = w_ready;
  assign bus.pending_hit1  = w_hit1;
  assign bus.pending_hit2  = w_hit2;
  assign bus.reg_wren      = r_wren;
  assign bus.write_address = r_writeAddress;
  assign bus.write_data    = r_writeData;
  assign bus.fifo_count    = r_count;

`ifdef WRITEBACK_BYPASS_EN
  assign bus.bypass_hit1  = r_wren && (r_writeAddress == bus.read_address1) && (bus.read_address1 != 5'd0);
  assign bus.bypass_hit2  = r_wren && (r_writeAddress == bus.read_address2) && (bus.read_address2 != 5'd0);
  assign bus.bypass_data1 = r_writeData;
  assign bus.bypass_data2 = r_writeData;
`endif
endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: per-scenario tasks plus a reference model
// whose expected register-file writes are queued and compared as the DUT emits them.
module tb_writeback_arbiter;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } entry_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  entry_t memQ[$];
  entry_t expQ[$];
  logic   expWren;

  writeback_arbiter_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  writeback_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each write the model predicts for this cycle is popped here and compared.
  always @(negedge clk) begin
    entry_t e;
    checks++;
    if (bus.reg_wren !== expWren) begin
      errors++;
      $display("[TB] FAIL reg_wren t=%0t got=%b exp=%b", $time, bus.reg_wren, expWren);
    end
    if (expWren) begin
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL scoreboard_empty t=%0t got=empty exp=entry", $time);
      end else begin
        e = expQ.pop_front();
        checks++;
        if (bus.write_address !== e.rd || bus.write_data !== e.data) begin
          errors++;
          $display("[TB] FAIL write_entry t=%0t got=%0d/%h exp=%0d/%h",
                   $time, bus.write_address, bus.write_data, e.rd, e.data);
        end
      end
    end
  end

  // One clock cycle: check combinational outputs against the model, advance the model, cross the edge.
  task automatic step();
    logic   nWren;
    logic   expReady;
    logic   expHit1;
    logic   expHit2;
    logic   aluReq;
    logic   doPush;
    entry_t e;
    entry_t pushE;
    #2;
    expReady = !reset && (memQ.size() != DEPTH);
    expHit1  = 1'b0;
    expHit2  = 1'b0;
    foreach (memQ[i]) begin
      if (bus.read_address1 != 5'd0 && memQ[i].rd == bus.read_address1) expHit1 = 1'b1;
      if (bus.read_address2 != 5'd0 && memQ[i].rd == bus.read_address2) expHit2 = 1'b1;
    end
    checks++;
    if (bus.mem_ready !== expReady) begin
      errors++;
      $display("[TB] FAIL mem_ready t=%0t got=%b exp=%b", $time, bus.mem_ready, expReady);
    end
    checks++;
    if (bus.fifo_count !== 3'(memQ.size())) begin
      errors++;
      $display("[TB] FAIL fifo_count t=%0t got=%0d exp=%0d", $time, bus.fifo_count, memQ.size());
    end
    checks++;
    if (bus.pending_hit1 !== expHit1 || bus.pending_hit2 !== expHit2) begin
      errors++;
      $display("[TB] FAIL pending_hit t=%0t got=%b%b exp=%b%b",
               $time, bus.pending_hit1, bus.pending_hit2, expHit1, expHit2);
    end
    nWren = 1'b0;
    e     = '0;
    if (reset) begin
      memQ.delete();
    end else begin
      aluReq = bus.alu_valid && (bus.alu_rd != 5'd0);
      doPush = bus.mem_valid && (memQ.size() != DEPTH) && (bus.mem_rd != 5'd0);
      pushE  = '{rd: bus.mem_rd, data: bus.mem_data};
      if (aluReq) begin
        nWren = 1'b1;
        e     = '{rd: bus.alu_rd, data: bus.alu_data};
      end else if (memQ.size() > 0) begin
        nWren = 1'b1;
        e     = memQ.pop_front();
      end
      if (doPush) memQ.push_back(pushE);
    end
    @(posedge clk);
    expWren = nWren;
    if (nWren) expQ.push_back(e);
    #1;
  endtask

  task automatic applyIdle();
    bus.alu_valid     = 1'b0;
    bus.alu_rd        = '0;
    bus.alu_data      = '0;
    bus.mem_valid     = 1'b0;
    bus.mem_rd        = '0;
    bus.mem_data      = '0;
    bus.read_address1 = '0;
    bus.read_address2 = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    applyIdle();
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (bus.reg_wren !== 1'b0 || bus.write_address !== 5'd0 || bus.write_data !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got=%b/%0d/%h exp=0/0/0",
               bus.reg_wren, bus.write_address, bus.write_data);
    end
    checks++;
    if (bus.mem_ready !== 1'b0 || bus.fifo_count !== 3'd0) begin
      errors++;
      $display("[TB] FAIL reset_fifo got=%b/%0d exp=0/0", bus.mem_ready, bus.fifo_count);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.mem_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_reset got=%b exp=1", bus.mem_ready);
    end
  endtask

  task automatic test_alu();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd5;
    bus.alu_data  = 32'h1234;
    step();
    applyIdle();
    checks++;
    if (bus.reg_wren !== 1'b1 || bus.write_address !== 5'd5 || bus.write_data !== 32'h1234) begin
      errors++;
      $display("[TB] FAIL alu_write got=%b/%0d/%h exp=1/5/1234",
               bus.reg_wren, bus.write_address, bus.write_data);
    end
    step();
    checks++;
    if (bus.reg_wren !== 1'b0) begin
      errors++;
      $display("[TB] FAIL alu_write_clear got=%b exp=0", bus.reg_wren);
    end
  endtask

  task automatic test_mem_latency();
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd7;
    bus.mem_data  = 32'hDEAD;
    step();
    applyIdle();
    checks++;
    if (bus.fifo_count !== 3'd1 || bus.reg_wren !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mem_queued got=%0d/%b exp=1/0", bus.fifo_count, bus.reg_wren);
    end
    step();
    checks++;
    if (bus.fifo_count !== 3'd0 || bus.reg_wren !== 1'b1 || bus.write_address !== 5'd7 ||
        bus.write_data !== 32'hDEAD) begin
      errors++;
      $display("[TB] FAIL mem_write got=%0d/%b/%0d/%h exp=0/1/7/dead",
               bus.fifo_count, bus.reg_wren, bus.write_address, bus.write_data);
    end
    step();
  endtask

  task automatic test_starve_fill();
    int idx;
    idx = 0;
    for (int i = 0; i < 8; i++) begin
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5'(i + 1);
      bus.alu_data  = 32'hA100 + i;
      bus.mem_valid = (idx < 5);
      bus.mem_rd    = 5'(10 + idx);
      bus.mem_data  = 32'hB000 + idx;
      #1;
      if (bus.mem_valid && bus.mem_ready) idx++;
      step();
    end
    applyIdle();
    #1;
    checks++;
    if (idx != 4 || bus.mem_ready !== 1'b0 || bus.fifo_count !== 3'd4) begin
      errors++;
      $display("[TB] FAIL fifo_full got=%0d/%b/%0d exp=4/0/4", idx, bus.mem_ready, bus.fifo_count);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (bus.reg_wren !== 1'b1 || bus.write_address !== 5'(10 + k) ||
          bus.write_data !== 32'hB000 + k || bus.fifo_count !== 3'(3 - k)) begin
        errors++;
        $display("[TB] FAIL drain_%0d got=%b/%0d/%h/%0d exp=1/%0d/%h/%0d", k, bus.reg_wren,
                 bus.write_address, bus.write_data, bus.fifo_count, 10 + k, 32'hB000 + k, 3 - k);
      end
    end
    step();
  endtask

  task automatic test_x0_drop();
    for (int i = 0; i < 4; i++) begin
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5'd0;
      bus.alu_data  = 32'hFFFF0000 + i;
      bus.mem_valid = 1'b1;
      bus.mem_rd    = 5'd0;
      bus.mem_data  = 32'hEEEE0000 + i;
      step();
      checks++;
      if (bus.reg_wren !== 1'b0 || bus.fifo_count !== 3'd0 || bus.mem_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL x0_drop got=%b/%0d/%b exp=0/0/1",
                 bus.reg_wren, bus.fifo_count, bus.mem_ready);
      end
    end
    applyIdle();
    step();
  endtask

  task automatic test_hazard();
    bus.alu_valid     = 1'b1;
    bus.alu_rd        = 5'd3;
    bus.alu_data      = 32'h3333;
    bus.mem_valid     = 1'b1;
    bus.mem_rd        = 5'd9;
    bus.mem_data      = 32'h9999;
    bus.read_address1 = 5'd9;
    bus.read_address2 = 5'd0;
    #1;
    checks++;
    if (bus.pending_hit1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hazard_offer_only got=%b exp=0", bus.pending_hit1);
    end
    step();
    bus.mem_valid = 1'b0;
    #1;
    checks++;
    if (bus.pending_hit1 !== 1'b1 || bus.pending_hit2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hazard_queued got=%b%b exp=10", bus.pending_hit1, bus.pending_hit2);
    end
    step();
    bus.alu_valid = 1'b0;
    step();
    checks++;
    if (bus.pending_hit1 !== 1'b0 || bus.write_address !== 5'd9) begin
      errors++;
      $display("[TB] FAIL hazard_popped got=%b/%0d exp=0/9", bus.pending_hit1, bus.write_address);
    end
    applyIdle();
    step();
  endtask

  task automatic test_reset_flush();
    bus.alu_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.alu_rd    = 5'(20 + i);
      bus.alu_data  = 32'hC000 + i;
      bus.mem_valid = 1'b1;
      bus.mem_rd    = 5'(24 + i);
      bus.mem_data  = 32'hD000 + i;
      step();
    end
    bus.mem_valid = 1'b0;
    reset   = 1'b1;
    memQ.delete();
    expQ.delete();
    expWren = 1'b0;
    #1;
    checks++;
    if (bus.fifo_count !== 3'd0 || bus.reg_wren !== 1'b0 || bus.mem_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flush got=%0d/%b/%b exp=0/0/0",
               bus.fifo_count, bus.reg_wren, bus.mem_ready);
    end
    applyIdle();
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 80; i++) begin
      bus.alu_valid     = ($urandom_range(0, 2) == 0);
      bus.alu_rd        = 5'($urandom_range(0, 7));
      bus.alu_data      = $urandom;
      bus.mem_valid     = ($urandom_range(0, 1) == 1);
      bus.mem_rd        = 5'($urandom_range(0, 7));
      bus.mem_data      = $urandom;
      bus.read_address1 = 5'($urandom_range(0, 7));
      bus.read_address2 = 5'($urandom_range(0, 7));
      step();
    end
    applyIdle();
    for (int i = 0; i < DEPTH + 2; i++) step();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    expWren = 1'b0;
    reset   = 1'b1;
    applyIdle();
    test_reset();
    test_alu();
    test_mem_latency();
    test_starve_fill();
    test_x0_drop();
    test_hazard();
    test_reset_flush();
    test_back_to_back();
    checks++;
    if (expQ.size() != 0 || memQ.size() != 0 || bus.fifo_count !== 3'd0) begin
      errors++;
      $display("[TB] FAIL final_drain got=%0d/%0d/%0d exp=0/0/0",
               expQ.size(), memQ.size(), bus.fifo_count);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout got=running exp=finished");
    $fatal(1, "[TB] timeout");
  end
endmodule
